shift_reg_pipo: RTL and testbench
=================================

# shift_reg_pipo

Parallel-in/parallel-out register block: captures a WIDTH-bit word on the rising clock edge and presents it on a parallel output after a fixed, configurable number of register stages. Used as a retiming/pipeline register between datapath blocks where a whole word moves per cycle, with no serial shifting. Optional load-enable gating is compiled in by macro.

## Interface
- WIDTH, 4: data width in bits (≥1).
- STAGES, 1: number of register stages between D and Q (≥1); sets latency.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into every stage by reset.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
- D  input  WIDTH  parallel data in.
- Q  output  WIDTH  parallel data out; driven directly from the last stage register, with no combinational path from D.
- load_en  input  1  present only with SHIFT_REG_PIPO_LOAD_EN; 1 = advance pipeline, 0 = hold.

## Operation
- Internal chain stage[0..STAGES-1], each WIDTH bits. Q = stage[STAGES-1].
- Each rising clk edge, in priority order:
  - reset=1: every stage <= RESET_VAL. Reset overrides load_en and D.
  - otherwise, if loading (load_en=1, or always when the macro is absent): stage[0] <= D; stage[k] <= stage[k-1] for k≥1.
  - otherwise (load_en=0): all stages hold.
- All stages move together. Stages are never partially updated.
- Data is passed through unmodified: no arithmetic, no width change, and every bit is independent.
- Before the first reset, the contents are undefined (X in simulation). The bench must not check Q until the first reset edge has occurred.
- Reset asserted mid-stream discards all in-flight words. After release, Q shows RESET_VAL until the first post-reset word emerges.

## Timing
- Latency: a D value sampled at edge n appears on Q just after edge n+STAGES-1 (STAGES=1: Q follows D one edge later, i.e. Q at edge n = D sampled at edge n).
- Throughput: one word per clock while loading.
- Reset: Q = RESET_VAL immediately after the first edge with reset=1. The first edge with reset=0 loads D into stage[0].
- reset held multiple cycles: Q stays RESET_VAL throughout.
- Simultaneous reset and load_en=1: reset wins.
- D, reset and load_en must be stable around the rising clk edge. Changes between edges have no effect.
- Hold: with load_en=0 for N cycles, Q and every stage are frozen for N cycles, and the latency count resumes when loading resumes.

## Configuration
- SHIFT_REG_PIPO_LOAD_EN defined: the load_en port exists and gates advancement as above.
- SHIFT_REG_PIPO_LOAD_EN undefined: the port is absent and the chain loads every non-reset cycle (four-port interface: clk, reset, D, Q).

## Test plan
- Reset: drive D=4'hF with reset=1 for 2 edges -> Q=4'h0 after each edge. Release reset -> Q=4'hF after the next edge.
- Streaming (WIDTH=4, STAGES=1): D=4'h3,4'hA,4'h5,4'hC,4'h1 on consecutive edges -> Q equals each value one edge after it was applied, with no drops and no repeats.
- Reset mid-stream: stream 4'h7,4'h9, assert reset for one edge -> Q=4'h0. Release with D=4'h2 -> Q=4'h2 next edge.
- Latency (STAGES=3): apply D=4'hB once, then 4'h0 -> Q=4'hB exactly after the third edge, with Q=RESET_VAL/prior data before that.
- Hold (macro defined): load 4'h6, set load_en=0 for 4 edges while D toggles 4'h1/4'hE -> Q stays 4'h6. Set load_en=1 -> Q takes the current D.
- Priority (macro defined): reset=1 and load_en=1 with D=4'hD -> Q=RESET_VAL, not 4'hD.

Source files
------------

// File: rtl/shift_reg_pipo.sv
// Parallel-in/parallel-out retiming register chain of STAGES words.
// Optional load-enable gating is compiled in with SHIFT_REG_PIPO_LOAD_EN.
module shift_reg_pipo #(
  parameter int unsigned          WIDTH     = 4,
  parameter int unsigned          STAGES    = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SHIFT_REG_PIPO_LOAD_EN
  input  logic             load_en,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] stage_r [STAGES];
  logic             advance_s;

  // Decide whether the whole chain advances on the next edge
  always_comb begin
    advance_s = 1'b1;
`ifdef SHIFT_REG_PIPO_LOAD_EN
    if (load_en) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
`endif
  end

  // Stage chain: reset beats load, and all stages move or hold together
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_r[k] <= RESET_VAL;
      end
    end else if (advance_s) begin
      stage_r[0] <= D;
      for (int k = 1; k < int'(STAGES); k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end else begin
      stage_r <= stage_r;
    end
  end

  assign Q = stage_r[STAGES-1];

endmodule

// File: tb/tb_shift_reg_pipo.sv
// Directed self-checking bench for shift_reg_pipo: three instances with
// different depth/reset value share one stimulus stream.
module tb_shift_reg_pipo;

  logic       clk;
  logic       reset;
  logic       load_en;
  logic [3:0] d;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;

  int n_checks;
  int n_fail;

  shift_reg_pipo #(.WIDTH(4), .STAGES(1), .RESET_VAL(4'h0)) u_s1 (
    .clk     (clk),
    .reset   (reset),
`ifdef SHIFT_REG_PIPO_LOAD_EN
    .load_en (load_en),
`endif
    .D       (d),
    .Q       (q1)
  );

  shift_reg_pipo #(.WIDTH(4), .STAGES(2), .RESET_VAL(4'hA)) u_s2 (
    .clk     (clk),
    .reset   (reset),
`ifdef SHIFT_REG_PIPO_LOAD_EN
    .load_en (load_en),
`endif
    .D       (d),
    .Q       (q2)
  );

  shift_reg_pipo #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'h0)) u_s3 (
    .clk     (clk),
    .reset   (reset),
`ifdef SHIFT_REG_PIPO_LOAD_EN
    .load_en (load_en),
`endif
    .D       (d),
    .Q       (q3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    load_en  = 1'b1;
    d        = 4'hF;

    // Reset held two edges with D=F
    step();
    check("rst1_q1", q1, 4'h0);
    check("rst1_q2", q2, 4'hA);
    check("rst1_q3", q3, 4'h0);
    step();
    check("rst2_q1", q1, 4'h0);
    check("rst2_q2", q2, 4'hA);
    check("rst2_q3", q3, 4'h0);

    // Release: first edge loads D
    reset = 1'b0;
    step();
    check("rel_q1", q1, 4'hF);
    check("rel_q2", q2, 4'hA);
    check("rel_q3", q3, 4'h0);

    // Streaming
    d = 4'h3; step();
    check("str3_q1", q1, 4'h3);
    check("str3_q2", q2, 4'hF);
    check("str3_q3", q3, 4'h0);
    d = 4'hA; step();
    check("strA_q1", q1, 4'hA);
    check("strA_q2", q2, 4'h3);
    check("strA_q3", q3, 4'hF);
    d = 4'h5; step();
    check("str5_q1", q1, 4'h5);
    check("str5_q3", q3, 4'h3);
    d = 4'hC; step();
    check("strC_q1", q1, 4'hC);
    check("strC_q3", q3, 4'hA);
    d = 4'h1; step();
    check("str1_q1", q1, 4'h1);
    check("str1_q2", q2, 4'hC);
    check("str1_q3", q3, 4'h5);

    // Reset mid-stream
    d = 4'h7; step();
    check("mid7_q1", q1, 4'h7);
    d = 4'h9; step();
    check("mid9_q1", q1, 4'h9);
    check("mid9_q3", q3, 4'h1);
    reset = 1'b1; step();
    check("midrst_q1", q1, 4'h0);
    check("midrst_q2", q2, 4'hA);
    check("midrst_q3", q3, 4'h0);
    reset = 1'b0; d = 4'h2; step();
    check("midrel_q1", q1, 4'h2);
    check("midrel_q2", q2, 4'hA);
    check("midrel_q3", q3, 4'h0);

    // Latency of the three-stage chain from a clean reset
    reset = 1'b1; step();
    reset = 1'b0; d = 4'hB; step();
    check("lat1_q1", q1, 4'hB);
    check("lat1_q3", q3, 4'h0);
    d = 4'h0; step();
    check("lat2_q3", q3, 4'h0);
    check("lat2_q2", q2, 4'hB);
    step();
    check("lat3_q3", q3, 4'hB);
    step();
    check("lat4_q3", q3, 4'h0);

`ifdef SHIFT_REG_PIPO_LOAD_EN
    // Hold with load_en low while D toggles
    d = 4'h6; step();
    check("hold_load_q1", q1, 4'h6);
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = (i % 2 == 0) ? 4'h1 : 4'hE;
      step();
      check("hold_q1", q1, 4'h6);
      check("hold_q2", q2, 4'h0);
      check("hold_q3", q3, 4'h0);
    end
    load_en = 1'b1; step();
    check("resume_q1", q1, 4'hE);
    check("resume_q2", q2, 4'h6);
    check("resume_q3", q3, 4'h0);

    // Reset beats load_en
    d = 4'hD; reset = 1'b1; load_en = 1'b1; step();
    check("prio_q1", q1, 4'h0);
    check("prio_q2", q2, 4'hA);
    check("prio_q3", q3, 4'h0);
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
